// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch unit: issues one 16-bit fetch at a time over a req/ack
// memory port, buffers returned words in a small FIFO and presents the head to
// the datapath. A redirect flushes the FIFO and squashes any in-flight fetch.
//
// Handshakes:
//   memory  : mem_req rises with mem_addr and both stay stable until the cycle
//             mem_ack is high; mem_rdata is only sampled in that cycle. A
//             request is never withdrawn, even when its data is unwanted.
//   datapath: the head word transfers on a rising clk edge where
//             instr_valid & instr_ready; a transfer coinciding with redirect is
//             ignored because the FIFO is being flushed.
module instr_prefetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        instr_valid,
    output logic [15:0] instr,
    output logic [15:0] instr_pc,
    input  logic        instr_ready,
    output logic [1:0]  dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     fetch_pc_q;
    logic            issue, push, pop;
    logic [CW-1:0]   count_q, count_after_pop, count_nxt;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q, rd_nxt;
    logic [15:0]     data_mem [DEPTH];
    logic [15:0]     pc_mem   [DEPTH];

    assign dbg_state = state_q;

    // Head consumption; a redirect in the same cycle wins over the pop.
    assign pop             = instr_valid && instr_ready && !redirect;
    assign count_after_pop = count_q - {{(CW-1){1'b0}}, pop};
    assign count_nxt       = count_after_pop + {{(CW-1){1'b0}}, push};
    assign rd_nxt          = rd_ptr_q + AW'(pop);

    // Fetch FSM next-state: one outstanding request, issue only with room free.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        push    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!redirect && (count_q < FULL_COUNT)) begin
                    issue   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    push    = !redirect;
                    state_d = ST_IDLE;
                end else if (redirect) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (mem_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered memory request and fetch PC tracking (redirect has priority).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= {RESET_PC[15:1], 1'b0};
            mem_req    <= 1'b0;
            mem_addr   <= 16'h0000;
        end else begin
            if (issue) begin
                mem_req  <= 1'b1;
                mem_addr <= fetch_pc_q;
            end else if (mem_ack && (state_q != ST_IDLE)) begin
                mem_req  <= 1'b0;
            end
            if (redirect) begin
                fetch_pc_q <= {redirect_pc[15:1], 1'b0};
            end else if (push) begin
                fetch_pc_q <= fetch_pc_q + 16'd2;
            end
        end
    end

    // FIFO storage; contents need no reset because count_q qualifies them.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= mem_rdata;
            pc_mem[wr_ptr_q]   <= mem_addr;
        end
    end

    // FIFO pointers, occupancy and registered head (held when empty).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            instr_valid <= 1'b0;
            instr       <= 16'h0000;
            instr_pc    <= 16'h0000;
        end else if (redirect) begin
            rd_ptr_q    <= wr_ptr_q;
            count_q     <= '0;
            instr_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            rd_ptr_q    <= rd_nxt;
            count_q     <= count_nxt;
            instr_valid <= (count_nxt != '0);
            if (count_nxt != '0) begin
                if (count_after_pop == '0) begin
                    // FIFO drains to empty this cycle: the new word becomes head.
                    instr    <= mem_rdata;
                    instr_pc <= mem_addr;
                end else begin
                    instr    <= data_mem[rd_nxt];
                    instr_pc <= pc_mem[rd_nxt];
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Bench for instr_prefetch_unit: memory responder, datapath consumer and an
// expected-word queue built from the architectural fetch rules.
module tb_instr_prefetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0000;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic [1:0]  dbg_state;

  instr_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .dbg_state   (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // scoreboard state: each entry is {instr, instr_pc}
  logic [31:0] exp_q[$];
  logic [15:0] pop_log[$];
  logic [15:0] exp_fetch;
  bit          squash, req_open, chk_bubble, rdy_cfg;
  int          idle_cycles;
  int          mem_mode;   // 0: automatic latency, 1: ack only when told
  int          lat_min, lat_max, cur_lat, wait_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] image(input logic [15:0] a);
    return {a[7:0] ^ 8'h3C, a[15:8] ^ 8'hA5} ^ 16'h1234;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    pop_log.delete();
    exp_fetch   = 16'h0000;
    squash      = 1'b0;
    req_open    = 1'b0;
    idle_cycles = 0;
    wait_cnt    = 0;
    chk_bubble  = 1'b0;
  endtask

  // One clock: drive inputs at negedge, observe, then model the next posedge.
  task automatic tick(input bit red, input logic [15:0] rpc, input bit fack);
    logic [31:0] e;
    @(negedge clk);
    redirect    = red;
    redirect_pc = rpc;
    instr_ready = rdy_cfg;
    if (!mem_req) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (mem_mode == 0) begin
      if (wait_cnt >= cur_lat) begin
        mem_ack  = 1'b1;
        wait_cnt = 0;
        cur_lat  = $urandom_range(lat_max, lat_min);
      end else begin
        mem_ack  = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ack = fack;
    end
    mem_rdata = mem_ack ? image(mem_addr) : 16'($urandom);

    check_eq("valid", {31'd0, instr_valid}, {31'd0, exp_q.size() != 0});
    if (mem_req && !req_open) begin
      check_eq("req_addr", {16'd0, mem_addr}, {16'd0, exp_fetch});
      check_eq("req_room", {31'd0, exp_q.size() < DEPTH}, 32'd1);
      if (chk_bubble) check_eq("bubble", idle_cycles, 32'd1);
      idle_cycles = 0;
      req_open    = 1'b1;
    end
    if (!mem_req) idle_cycles++;

    if (instr_valid && rdy_cfg && !red && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_eq("instr", {16'd0, instr}, {16'd0, e[31:16]});
      check_eq("instr_pc", {16'd0, instr_pc}, {16'd0, e[15:0]});
      pop_log.push_back(instr_pc);
    end

    if (red) begin
      exp_q.delete();
      exp_fetch = {rpc[15:1], 1'b0};
    end
    if (mem_req && mem_ack) begin
      req_open = 1'b0;
      if (!red && !squash) begin
        exp_q.push_back({image(mem_addr), mem_addr});
        exp_fetch = exp_fetch + 16'd2;
      end
      squash = 1'b0;
    end else if (mem_req && red) begin
      squash = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    redirect    = 1'b0;
    instr_ready = 1'b0;
    mem_ack     = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic run_until_pops(input int n, input int budget);
    int i;
    for (i = 0; i < budget && pop_log.size() < n; i++) tick(1'b0, 16'h0000, 1'b0);
    if (pop_log.size() < n) check_eq("pop_timeout", pop_log.size(), n);
  endtask

  task automatic check_seq(input string tag, input logic [15:0] start, input int n);
    logic [15:0] got;
    for (int i = 0; i < n; i++) begin
      got = (i < pop_log.size()) ? pop_log[i] : 16'hxxxx;
      check_eq(tag, {16'd0, got}, {16'd0, 16'(start + 16'(2 * i))});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"},   {31'd0, mem_req}, 32'd0);
    check_eq({tag, "_addr"},  {16'd0, mem_addr}, 32'd0);
    check_eq({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    check_eq({tag, "_instr"}, {16'd0, instr}, 32'd0);
    check_eq({tag, "_pc"},    {16'd0, instr_pc}, 32'd0);
    check_eq({tag, "_state"}, {30'd0, dbg_state}, 32'd0);
  endtask

  initial begin
    mem_mode = 0; lat_min = 1; lat_max = 1; cur_lat = 1; rdy_cfg = 1'b0;
    model_clear();

    // reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    do_reset();

    // 1: streaming with latency 1, consumer always ready
    rdy_cfg = 1'b1; mem_mode = 0; lat_min = 1; lat_max = 1; cur_lat = 1;
    run_until_pops(1, 20);
    chk_bubble = 1'b1;
    run_until_pops(8, 100);
    chk_bubble = 1'b0;
    check_seq("t1_seq", 16'h0000, 8);

    // 2: consumer stalled, random latency, FIFO fills to DEPTH
    do_reset();
    rdy_cfg = 1'b0; lat_min = 0; lat_max = 3; cur_lat = 2;
    repeat (40) tick(1'b0, 16'h0000, 1'b0);
    check_eq("t2_req_full", {31'd0, mem_req}, 32'd0);
    check_eq("t2_valid", {31'd0, instr_valid}, 32'd1);
    check_eq("t2_head", {16'd0, instr_pc}, 32'd0);
    repeat (3) begin
      tick(1'b0, 16'h0000, 1'b0);
      check_eq("t2_req_hold", {31'd0, mem_req}, 32'd0);
    end
    rdy_cfg = 1'b1;
    run_until_pops(6, 100);
    check_seq("t2_seq", 16'h0000, 6);

    // 3: redirect while a request waits, request held until acked
    mem_mode = 1;
    tick(1'b1, 16'h0010, 1'b0);
    tick(1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 20 && !(mem_req && mem_addr == 16'h0010); i++) tick(1'b0, 16'h0000, 1'b0);
    check_eq("t3_req_up", {31'd0, mem_req}, 32'd1);
    tick(1'b1, 16'h0041, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 16'h0000, 1'b0);
      check_eq("t3_req_held", {31'd0, mem_req}, 32'd1);
      check_eq("t3_addr_held", {16'd0, mem_addr}, 32'h0010);
    end
    tick(1'b0, 16'h0000, 1'b1);
    mem_mode = 0; lat_min = 1; lat_max = 2; cur_lat = 1; wait_cnt = 0;
    pop_log.delete();
    run_until_pops(2, 60);
    check_seq("t3_seq", 16'h0040, 2);

    // 4: redirect coincident with ack and ready, FIFO holding two words
    rdy_cfg = 1'b0; mem_mode = 1;
    for (int i = 0; i < 40 && exp_q.size() < 2; i++) tick(1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 10 && !mem_req; i++) tick(1'b0, 16'h0000, 1'b0);
    check_eq("t4_req_up", {31'd0, mem_req}, 32'd1);
    check_eq("t4_valid", {31'd0, instr_valid}, 32'd1);
    rdy_cfg = 1'b1;
    tick(1'b1, 16'h0100, 1'b1);
    tick(1'b0, 16'h0000, 1'b0);
    check_eq("t4_flushed", {31'd0, instr_valid}, 32'd0);
    mem_mode = 0; lat_min = 0; lat_max = 2; cur_lat = 0; wait_cnt = 0;
    pop_log.delete();
    run_until_pops(2, 60);
    check_seq("t4_seq", 16'h0100, 2);

    // 5: fetch PC wraps through 0xFFFE
    tick(1'b1, 16'hFFFC, 1'b0);
    pop_log.delete();
    run_until_pops(4, 80);
    check_seq("t5_wrap", 16'hFFFC, 4);

    // 6: reset mid-request with an ack landing during reset
    mem_mode = 1;
    for (int i = 0; i < 20 && !mem_req; i++) tick(1'b0, 16'h0000, 1'b0);
    check_eq("t6_req_up", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 16'hDEAD; redirect = 1'b0;
    @(negedge clk);
    check_reset_outputs("t6_hold");
    mem_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    mem_mode = 0; lat_min = 1; lat_max = 3; cur_lat = 1;
    run_until_pops(3, 80);
    check_seq("t6_seq", 16'h0000, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // overall time bound
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
